lcd_write_ctrl: RTL and testbench
=================================

# lcd_write_ctrl

Parametrised HD44780-class character-LCD write controller that drives the 8-bit parallel LCD pins (rw, rs, enable, data) of the board. It performs the power-on initialisation sequence by itself and buffers command/data bytes in an internal FIFO. Each byte is issued with programmable setup, enable-pulse, hold and execution-wait timing, so the processor side only pushes bytes and never busy-waits.

## Interface
- CLK_HZ, 50000000, clock frequency; informational only, all timing is given in cycles
- DEPTH, 16, FIFO entries; power of two, at least 2
- SETUP_CYCLES, 4, rs/data setup before enable rises; also hold after enable falls; at least 1
- EN_CYCLES, 12, enable high width; at least 1
- CMD_WAIT_CYCLES, 2000, post-write wait for ordinary commands and data; at least 1
- CLEAR_WAIT_CYCLES, 82000, post-write wait for clear (0x01) and home (0x02/0x03) commands
- INIT_WAIT_CYCLES, 750000, power-on wait before the first init command
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- wr_valid  in  1  push request
- wr_ready  out  1  FIFO not full
- wr_rs  in  1  0 = command, 1 = data
- wr_data  in  8  byte to write
- busy  out  1  high unless the FSM is in IDLE with an empty FIFO
- init_done  out  1  set after the init sequence completes; cleared only by reset
- lcd_rw_writeresponsevalid_n  out  1  LCD R/W; held at 0 (write only)
- lcd_rs_writeresponsevalid_n  out  1  LCD RS
- lcd_enable_writeresponsevalid_n  out  1  LCD E
- lcd_display_readdata  out  8  LCD DB[7:0]

## Operation
- Reset values: all LCD outputs 0; init_done 0; busy 1; wr_ready 1; FIFO empty; state INIT_WAIT with its counter cleared. Reset mid-transaction forces enable low on the next edge.
- FIFO: 9-bit entries {rs, data}, DEPTH deep, occupancy counter of width $clog2(DEPTH)+1.
  - A push happens when wr_valid and wr_ready are both high.
  - wr_ready is combinational: it is the negation of full, taken from the registered count.
  - A push while full is dropped, including when a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pushes are accepted during initialisation.
- Init sequence, issued in order after INIT_WAIT_CYCLES: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on), 0x01 (clear), 0x06 (entry increment). All have rs=0. After the final wait completes, init_done is set.
- FSM states:
  - INIT_WAIT: go to LOAD after INIT_WAIT_CYCLES.
  - IDLE: if init_done and the FIFO is non-empty, pop and go to LOAD.
  - LOAD: one cycle; latch rs/data onto the pins.
  - SETUP: SETUP_CYCLES cycles; enable low.
  - PULSE: EN_CYCLES cycles; enable high.
  - HOLD: SETUP_CYCLES cycles; enable low.
  - WAIT: CMD_WAIT_CYCLES or CLEAR_WAIT_CYCLES cycles.
  - After WAIT: go to IDLE if init is done; otherwise go to LOAD with the next init command.
- Wait selection: use CLEAR_WAIT_CYCLES when rs=0 and data[7:2]=0 and data is not 0x00. Use CMD_WAIT_CYCLES otherwise.
- rs and data keep their last values after HOLD; they change only in LOAD.
- A single down-counter, sized to the maximum parameter, is reloaded on every state entry.

## Timing
- Pop in IDLE at cycle t; pins change at the t+1 edge (LOAD).
- Enable is high for exactly EN_CYCLES cycles, starting SETUP_CYCLES cycles after the LOAD cycle.
- Next pop is possible at cycle t+1+1+2·SETUP_CYCLES+EN_CYCLES+wait.
- busy falls in the same cycle the FSM enters IDLE with an empty FIFO. It rises combinationally on a push.
- Enable never glitches: it is registered and driven only by state.

## Test plan
Bench parameters: DEPTH=4, SETUP=2, EN=3, CMD_WAIT=5, CLEAR_WAIT=10, INIT_WAIT=20.
- Reset, then idle -> after 20 cycles, four enable pulses of 3 cycles each carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. The gap after 0x01 is 10 cycles; the other gaps are 5. init_done rises after the last wait; rw stays 0 throughout.
- After init, push {rs=1, 0x41} -> rs=1 and data=0x41 appear 1 cycle after the pop. Enable is high for 3 cycles, starting 2 cycles later. busy falls 2+5 cycles after enable falls.
- Push 6 bytes back-to-back during init -> wr_ready low after 4 accepted. The 5th and 6th are dropped. Exactly 4 bytes are emitted in order after init_done.
- Push command 0x02 then data 0x30 -> the wait after 0x02 is 10 cycles and the wait after 0x30 is 5 cycles.
- Assert reset_reset_n low during PULSE -> enable low on the next edge. FIFO is empty, init_done is 0, and the init sequence restarts after release.
- Push on the same cycle as a pop with FIFO count 3 -> count stays 3 and order is preserved.

Source files
------------

// File: rtl/lcd_write_ctrl_if.sv
// Write-side handshake bundle for lcd_write_ctrl.
//   wr_valid : push request from the processor side
//   wr_ready : controller can accept a byte (FIFO not full)
//   wr_rs    : 0 = command byte, 1 = data byte
//   wr_data  : byte to write
// master = processor side, slave = controller side.
interface lcd_write_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_write_ctrl.sv
// HD44780-class character-LCD write controller (8-bit bus, write only).
// Runs the power-on init sequence on its own, then drains a {rs, data}
// FIFO onto the LCD pins with setup / enable / hold / execution-wait timing.
//
// Ports:
//   clk_clk                          system clock, rising edge
//   reset_reset_n                    synchronous active-low reset
//   wr (lcd_write_ctrl_if.slave)     push handshake: wr_valid/wr_ready/wr_rs/wr_data
//   busy                             high unless IDLE with an empty FIFO
//   init_done                        init sequence finished (sticky until reset)
//   lcd_rw_writeresponsevalid_n      LCD R/W, constant 0
//   lcd_rs_writeresponsevalid_n      LCD RS
//   lcd_enable_writeresponsevalid_n  LCD E (registered, state-driven)
//   lcd_display_readdata             LCD DB[7:0]
//
// state     | meaning
// INIT_WAIT | power-on delay before the first init command
// IDLE      | waiting for a FIFO entry (after init)
// LOAD      | rs/data latched onto the pins
// SETUP     | address/data setup, E low
// PULSE     | E high
// HOLD      | address/data hold, E low
// WAIT      | LCD execution time (command or clear/home)
module lcd_write_ctrl #(
  parameter int CLK_HZ            = 50000000,
  parameter int DEPTH             = 16,
  parameter int SETUP_CYCLES      = 4,
  parameter int EN_CYCLES         = 12,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int INIT_WAIT_CYCLES  = 750000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  lcd_write_ctrl_if.slave   wr,
  output logic              busy,
  output logic              init_done,
  output logic              lcd_rw_writeresponsevalid_n,
  output logic              lcd_rs_writeresponsevalid_n,
  output logic              lcd_enable_writeresponsevalid_n,
  output logic [7:0]        lcd_display_readdata
);

  if (CLK_HZ < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SETUP_CYCLES < 1 ||
      EN_CYCLES < 1 || CMD_WAIT_CYCLES < 1 || CLEAR_WAIT_CYCLES < 1 ||
      INIT_WAIT_CYCLES < 1) begin : g_param_check
    $error("lcd_write_ctrl: invalid parameter set");
  end

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_B = (MAX_A > CMD_WAIT_CYCLES) ? MAX_A : CMD_WAIT_CYCLES;
  localparam int MAX_C = (MAX_B > CLEAR_WAIT_CYCLES) ? MAX_B : CLEAR_WAIT_CYCLES;
  localparam int MAX_T = (MAX_C > INIT_WAIT_CYCLES) ? MAX_C : INIT_WAIT_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_cmd = 8'h0C;  // display on, cursor off
      2'd2:    init_cmd = 8'h01;  // clear
      default: init_cmd = 8'h06;  // entry mode: increment
    endcase
  endfunction

  // FIFO
  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  // FSM / datapath
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          rs_q, rs_d, en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic          is_clear;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign wr.wr_ready = ~full;
  assign push        = wr.wr_valid & ~full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr.wr_rs, wr.wr_data};
  end

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  assign is_clear = ~rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'h00);

  // State register (also holds the FIFO pointers and pin registers)
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_INIT_WAIT;
      tmr_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Next-state. The timer reloads with (duration - 1) on every state entry
  // and counts down to zero. INIT_WAIT is the one exception: it is entered
  // only from reset, where the timer is cleared, so it counts up instead.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    pop         = 1'b0;
    case (state_q)
      S_INIT_WAIT: begin
        if (tmr_q == TW'(INIT_WAIT_CYCLES - 1)) begin
          state_d = S_LOAD;
          tmr_d   = '0;
          idx_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (init_done_q && !empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
          tmr_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_SETUP;
        tmr_d   = TW'(SETUP_CYCLES - 1);
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_PULSE;
          tmr_d   = TW'(EN_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          state_d = S_HOLD;
          tmr_d   = TW'(SETUP_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_WAIT;
          tmr_d   = is_clear ? TW'(CLEAR_WAIT_CYCLES - 1) : TW'(CMD_WAIT_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (tmr_q == '0) begin
          tmr_d = '0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the pins change on the
  // same edge the FSM enters LOAD / PULSE, and E can never glitch.
  always_comb begin
    rs_d   = rs_q;
    data_d = data_q;
    en_d   = (state_d == S_PULSE);
    if (state_d == S_LOAD) begin
      if (state_q == S_IDLE) begin
        {rs_d, data_d} = mem_q[rd_ptr_q];
      end else begin
        rs_d   = 1'b0;
        data_d = init_cmd(idx_d);
      end
    end
  end

  assign busy                            = ~((state_q == S_IDLE) && empty && ~push);
  assign init_done                       = init_done_q;
  assign lcd_rw_writeresponsevalid_n     = 1'b0;
  assign lcd_rs_writeresponsevalid_n     = rs_q;
  assign lcd_enable_writeresponsevalid_n = en_q;
  assign lcd_display_readdata            = data_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
module tb_lcd_write_ctrl;
  localparam int DEPTH  = 4;
  localparam int SETUP  = 2;
  localparam int EN     = 3;
  localparam int CMD_W  = 5;
  localparam int CLR_W  = 10;
  localparam int INIT_W = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, init_done, lcd_rw, lcd_rs, lcd_en;
  logic [7:0] lcd_db;

  always #5 clk = ~clk;

  lcd_write_ctrl_if wif ();

  lcd_write_ctrl #(
    .CLK_HZ(100000000), .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .EN_CYCLES(EN),
    .CMD_WAIT_CYCLES(CMD_W), .CLEAR_WAIT_CYCLES(CLR_W), .INIT_WAIT_CYCLES(INIT_W)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .wr(wif),
    .busy(busy),
    .init_done(init_done),
    .lcd_rw_writeresponsevalid_n(lcd_rw),
    .lcd_rs_writeresponsevalid_n(lcd_rs),
    .lcd_enable_writeresponsevalid_n(lcd_en),
    .lcd_display_readdata(lcd_db)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;   // expected E-low cycles before this pulse, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endfunction

  function automatic void expect_byte(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  // Init sequence: first E rises INIT+LOAD+SETUP = 23 cycles after reset;
  // between init bytes E is low for HOLD+WAIT+LOAD+SETUP = wait+5.
  function automatic void expect_init();
    expect_byte(1'b0, 8'h38, INIT_W + 1 + SETUP);
    expect_byte(1'b0, 8'h0C, 2*SETUP + 1 + CMD_W);
    expect_byte(1'b0, 8'h01, 2*SETUP + 1 + CMD_W);
    expect_byte(1'b0, 8'h06, 2*SETUP + 1 + CLR_W);
  endfunction

  // Monitor: every E rising edge pops one expected byte; every falling edge
  // checks the pulse width.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        // the first counting edge after release is the next one
        fall_cyc = cyc + 1;
        en_prev  = 1'b0;
      end else begin
        if (lcd_en && !en_prev) begin
          rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'(lcd_db), -1);
          end else begin
            e = exp_q.pop_front();
            check("pulse_rs", int'(lcd_rs), int'(e.rs));
            check("pulse_data", int'(lcd_db), int'(e.data));
            check("pulse_rw", int'(lcd_rw), 0);
            if (e.gap > 0) check("pulse_gap", cyc - fall_cyc, e.gap);
          end
        end else if (!lcd_en && en_prev) begin
          fall_cyc = cyc;
          check("pulse_width", cyc - rise_cyc, EN);
        end
        en_prev = lcd_en;
      end
    end
  end

  // Caller is at a negedge; returns at the negedge where reset is released.
  task automatic do_reset();
    rst_n = 1'b0;
    wif.wr_valid = 1'b0;
    @(negedge clk);
    check("rst_en_next_edge", int'(lcd_en), 0);
    @(negedge clk);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_data", int'(lcd_db), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_wr_ready", int'(wif.wr_ready), 1);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    wif.wr_valid = 1'b1;
    wif.wr_rs    = rs;
    wif.wr_data  = d;
    @(negedge clk);
    wif.wr_valid = 1'b0;
  endtask

  // Idle follows the last E fall by HOLD + CMD wait = 7 cycles.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
    check("idle_after_fall", cyc - fall_cyc, SETUP + CMD_W);
    check("idle_init_done", int'(init_done), 1);
  endtask

  initial begin
    int n;
    wif.wr_valid = 1'b0;
    wif.wr_rs    = 1'b0;
    wif.wr_data  = 8'h00;

    // Power-on init
    @(negedge clk);
    do_reset();
    expect_init();
    repeat (60) @(negedge clk);
    check("init_done_early", int'(init_done), 0);
    wait_idle();

    // Single data byte: pins change one cycle after the pop
    expect_byte(1'b1, 8'h41, 0);
    wif.wr_valid = 1'b1; wif.wr_rs = 1'b1; wif.wr_data = 8'h41;
    #1;
    check("busy_comb_rise", int'(busy), 1);
    @(negedge clk);
    wif.wr_valid = 1'b0;
    check("pins_before_load", int'(lcd_db), 8'h06);
    @(negedge clk);
    check("load_rs", int'(lcd_rs), 1);
    check("load_data", int'(lcd_db), 8'h41);
    check("load_en_low", int'(lcd_en), 0);
    wait_idle();
    check("data_held", int'(lcd_db), 8'h41);

    // Home command uses the long wait, data byte the short one
    expect_byte(1'b0, 8'h02, 0);
    expect_byte(1'b1, 8'h30, 2*SETUP + 2 + CLR_W);
    push(1'b0, 8'h02);
    push(1'b1, 8'h30);
    wait_idle();

    // Push coincident with a pop at count 3
    expect_byte(1'b1, 8'h61, 0);
    for (int i = 2; i <= 6; i++) expect_byte(1'b1, 8'(8'h60 + i), 2*SETUP + 2 + CMD_W);
    for (int i = 0; i < 18; i++) begin
      wif.wr_valid = 1'b0;
      if (i < 4) begin
        wif.wr_valid = 1'b1; wif.wr_rs = 1'b1; wif.wr_data = 8'(8'h61 + i);
      end else if (i == 15) begin
        check("ready_cnt3_pre", int'(wif.wr_ready), 1);
        wif.wr_valid = 1'b1; wif.wr_data = 8'h65;
      end else if (i == 16) begin
        check("ready_cnt3_after_pushpop", int'(wif.wr_ready), 1);
        wif.wr_valid = 1'b1; wif.wr_data = 8'h66;
      end else if (i == 17) begin
        check("ready_full", int'(wif.wr_ready), 0);
      end
      @(negedge clk);
    end
    wif.wr_valid = 1'b0;
    wait_idle();

    // Overfill during init: 4 accepted, 2 dropped
    do_reset();
    expect_init();
    for (int i = 1; i <= 4; i++) expect_byte(1'b1, 8'(8'hA0 + i), 2*SETUP + 2 + CMD_W);
    for (int i = 0; i < 6; i++) begin
      wif.wr_valid = 1'b1; wif.wr_rs = 1'b1; wif.wr_data = 8'(8'hA1 + i);
      check("ready_fill", int'(wif.wr_ready), (i < DEPTH) ? 1 : 0);
      @(negedge clk);
    end
    wif.wr_valid = 1'b0;
    wait_idle();

    // Reset during PULSE flushes FIFO and restarts init
    expect_byte(1'b1, 8'h55, 0);
    push(1'b1, 8'h55);
    push(1'b1, 8'h66);
    push(1'b1, 8'h77);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pulse_seen", int'(lcd_en), 1);
    @(negedge clk);
    do_reset();
    expect_init();
    wait_idle();

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
